// File: rtl/wb_regbank.sv
// Wishbone register bank: NOUT read/write output words, NIN synchronized
// read-only input words, a write-1-to-clear change register (CHG) and an
// interrupt mask (MASK) that together drive a level interrupt.
module wb_regbank #(
    parameter int          NOUT       = 2,
    parameter int          NIN        = 2,
    parameter int          AW         = 4,
    parameter logic [31:0] PULSE_MASK = 32'h0,
    parameter logic [31:0] RESET_VAL  = 32'h0
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_adr,
    input  logic [3:0]           wb_sel,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack,
    output logic [NOUT*32-1:0]   reg_o,
    input  logic [NIN*32-1:0]    reg_i,
    output logic                 irq
);

    localparam logic [31:0] ADR_CHG  = 32'(NOUT + NIN);
    localparam logic [31:0] ADR_MASK = 32'(NOUT + NIN + 1);

    logic [NOUT-1:0][31:0] out_q, out_d;
    logic [NIN-1:0][31:0]  sync1_q, sync1_d;
    logic [NIN-1:0][31:0]  sync2_q, sync2_d;
    logic [NIN-1:0][31:0]  sync3_q, sync3_d;
    logic [NIN-1:0]        chg_q, chg_d;
    logic [NIN-1:0]        mask_q, mask_d;
    logic [NIN-1:0]        chg_set, chg_clr;
    logic [31:0]           dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  irq_q, irq_d;

    logic                  accept;
    logic [31:0]           adr_ext;
    logic [31:0]           wmask;
    logic [31:0]           rd_data;

    // Request acceptance; the ack itself blocks a new accept for one cycle.
    always_comb begin
        adr_ext = 32'(wb_adr);
        accept  = wb_cyc & wb_stb & ~ack_q;
        ack_d   = accept;
        for (int k = 0; k < 4; k++) begin
            wmask[8*k +: 8] = {8{wb_sel[k]}};
        end
    end

    // Read mux; unmapped addresses and unused CHG/MASK bits return zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (adr_ext == 32'(i)) rd_data = out_q[i];
        end
        for (int j = 0; j < NIN; j++) begin
            if (adr_ext == 32'(NOUT + j)) rd_data = sync2_q[j];
        end
        if (adr_ext == ADR_CHG)  rd_data = 32'(chg_q);
        if (adr_ext == ADR_MASK) rd_data = 32'(mask_q);
        dat_d = (accept && !wb_we) ? rd_data : dat_q;
    end

    // Output registers: pulse bits drop every cycle, writes merge by byte lane.
    always_comb begin
        for (int i = 0; i < NOUT; i++) begin
            out_d[i] = out_q[i] & ~PULSE_MASK;
            if (accept && wb_we && (adr_ext == 32'(i))) begin
                out_d[i] = (wb_dat_i & wmask) | (out_q[i] & ~PULSE_MASK & ~wmask);
            end
        end
    end

    // Input synchronizers, change detection, W1C clear (set wins) and mask.
    always_comb begin
        sync1_d = reg_i;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        chg_clr = '0;
        mask_d  = mask_q;
        for (int j = 0; j < NIN; j++) begin
            chg_set[j] = (sync2_q[j] != sync3_q[j]);
        end
        if (accept && wb_we && (adr_ext == ADR_CHG)) begin
            chg_clr = wb_dat_i[NIN-1:0] & wmask[NIN-1:0];
        end
        if (accept && wb_we && (adr_ext == ADR_MASK)) begin
            mask_d = (wb_dat_i[NIN-1:0] & wmask[NIN-1:0]) | (mask_q & ~wmask[NIN-1:0]);
        end
        chg_d = (chg_q & ~chg_clr) | chg_set;
        irq_d = |(chg_q & mask_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            out_q   <= {NOUT{RESET_VAL}};
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            chg_q   <= '0;
            mask_q  <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            chg_q   <= chg_d;
            mask_q  <= mask_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            irq_q   <= irq_d;
        end
    end

    assign reg_o    = out_q;
    assign wb_dat_o = dat_q;
    assign wb_ack   = ack_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_wb_regbank.sv
// Bench for wb_regbank: a main instance with nonzero reset value and a second
// instance with bit 0 as a pulse bit, both sharing one Wishbone bus.
module tb_wb_regbank;

    localparam logic [31:0] RV = 32'h0BAD_F00D;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o, p_dat_o;
    logic        wb_ack, p_ack;
    logic [63:0] reg_o, p_reg_o;
    logic [63:0] reg_i;
    logic        irq, p_irq;

    typedef struct packed {
        logic        rd;
        logic [31:0] d;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         ent;
    logic [31:0] out_m [2];
    int          n_chk = 0;
    int          n_err = 0;
    int          lat;

    always #5 wb_clk = ~wb_clk;

    wb_regbank #(.NOUT(2), .NIN(2), .AW(4), .PULSE_MASK(32'h0), .RESET_VAL(RV)) u_dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .reg_o(reg_o), .reg_i(reg_i), .irq(irq)
    );

    wb_regbank #(.NOUT(2), .NIN(2), .AW(4), .PULSE_MASK(32'h1), .RESET_VAL(32'h0)) u_pls (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
        .wb_dat_o(p_dat_o), .wb_ack(p_ack), .reg_o(p_reg_o), .reg_i(reg_i), .irq(p_irq)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    // Scoreboard: every ack pops one entry; reads compare the returned data.
    always @(negedge wb_clk) begin
        if (wb_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_ack", 64'(wb_ack), 64'(0));
            end else begin
                ent = sb_q.pop_front();
                if (ent.rd) chk("rd_data", 64'(wb_dat_o), 64'(ent.d));
            end
        end
    end

    // Called just after a negedge; returns just after a negedge with the bus idle.
    task automatic bus(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] exp, output int l);
        sb_q.push_back(sb_t'{rd: !we, d: exp});
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
        l = 0;
        do begin
            @(posedge wb_clk); #1;
            l++;
        end while (wb_ack !== 1'b1 && l < 4);
        chk("bus_ack", 64'(wb_ack), 64'(1));
        if (we && adr < 4'd2) out_m[adr[0]] = merge(out_m[adr[0]], dat, sel);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge wb_clk); #1;
        chk("ack_1cyc", 64'(wb_ack), 64'(0));
        if (we) chk("reg_o_model", reg_o, {out_m[1], out_m[0]});
        @(negedge wb_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wb_rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_dat_i = '0;
        reg_i = '0;
        out_m[0] = RV; out_m[1] = RV;
        repeat (3) @(negedge wb_clk);

        chk("rst_ack", 64'(wb_ack), 64'(0));
        chk("rst_dat", 64'(wb_dat_o), 64'(0));
        chk("rst_irq", 64'(irq), 64'(0));
        chk("rst_reg_o", reg_o, {RV, RV});
        chk("rst_p_reg_o", p_reg_o, 64'(0));

        // Release reset and present a request in the same cycle.
        wb_rst_n = 1'b1;
        bus(1'b1, 4'd1, 4'hF, 32'h1122_3344, 32'h0, lat);
        chk("first_accept", 64'(lat), 64'(1));

        // Byte-lane write and readback.
        bus(1'b1, 4'd1, 4'b0101, 32'hA5A5_A5A5, 32'h0, lat);
        bus(1'b0, 4'd1, 4'h0, 32'h0, 32'h11A5_33A5, lat);
        chk("reg_o_hi", 64'(reg_o[63:32]), 64'(32'h11A5_33A5));

        // Read data holds across a write.
        bus(1'b1, 4'd0, 4'hF, 32'hCAFE_0001, 32'h0, lat);
        chk("dat_hold", 64'(wb_dat_o), 64'(32'h11A5_33A5));

        // Pulse bit: visible for exactly one cycle.
        sb_q.push_back(sb_t'{rd: 1'b0, d: 32'h0});
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 4'd0; wb_sel = 4'hF; wb_dat_i = 32'h3;
        out_m[0] = 32'h3;
        @(posedge wb_clk); #1;
        chk("pulse_on", 64'(p_reg_o[1:0]), 64'(2'b11));
        chk("pulse_ack", 64'(wb_ack), 64'(1));
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge wb_clk); #1;
        chk("pulse_off", 64'(p_reg_o[1:0]), 64'(2'b10));
        chk("nopulse_reg", 64'(reg_o[31:0]), 64'(32'h3));
        @(posedge wb_clk); #1;
        chk("pulse_stays", 64'(p_reg_o[1:0]), 64'(2'b10));
        @(negedge wb_clk);
        bus(1'b0, 4'd0, 4'h0, 32'h0, 32'h3, lat);
        chk("pulse_rb", 64'(p_dat_o), 64'(32'h2));

        // Input change, CHG, MASK and irq timing.
        bus(1'b1, 4'd5, 4'hF, 32'h1, 32'h0, lat);
        reg_i[31:0] = 32'h55;
        for (int i = 1; i <= 4; i++) begin
            @(posedge wb_clk); #1;
            chk($sformatf("irq_lat%0d", i), 64'(irq), 64'(i == 4));
        end
        @(negedge wb_clk);
        bus(1'b0, 4'd2, 4'h0, 32'h0, 32'h55, lat);
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h1, lat);
        bus(1'b0, 4'd5, 4'h0, 32'h0, 32'h1, lat);
        chk("irq_set", 64'(irq), 64'(1));
        bus(1'b1, 4'd4, 4'hF, 32'h1, 32'h0, lat);
        chk("irq_clr", 64'(irq), 64'(0));
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h0, lat);

        // Set and W1C of CHG[1] on the same edge: set wins.
        reg_i[63:32] = 32'h0000_1234;
        repeat (4) @(negedge wb_clk);
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h2, lat);
        reg_i[63:32] = 32'h0000_5678;
        @(negedge wb_clk);
        @(negedge wb_clk);
        bus(1'b1, 4'd4, 4'hF, 32'h2, 32'h0, lat);
        chk("coincide_lat", 64'(lat), 64'(1));
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h2, lat);
        bus(1'b1, 4'd4, 4'hF, 32'h2, 32'h0, lat);
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h0, lat);
        chk("irq_unmasked", 64'(irq), 64'(0));

        // Continuous strobe on an unmapped address.
        bus(1'b0, 4'd1, 4'h0, 32'h0, 32'h11A5_33A5, lat);
        for (int i = 0; i < 3; i++) sb_q.push_back(sb_t'{rd: 1'b1, d: 32'h0});
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'd7;
        #1;
        chk("b2b_ack0", 64'(wb_ack), 64'(0));
        for (int i = 1; i < 6; i++) begin
            @(negedge wb_clk);
            chk($sformatf("b2b_ack%0d", i), 64'(wb_ack), 64'(i % 2));
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge wb_clk);
        @(negedge wb_clk);

        // Reset in the middle of an accepted write.
        reg_i[31:0] = 32'hAA;
        repeat (5) @(negedge wb_clk);
        chk("pre_rst_irq", 64'(irq), 64'(1));
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 4'd0; wb_sel = 4'hF; wb_dat_i = 32'hFFFF_FFFF;
        wb_rst_n = 1'b0;
        @(posedge wb_clk); #1;
        chk("rst_wr_ack", 64'(wb_ack), 64'(0));
        chk("rst_wr_reg_o", reg_o, {RV, RV});
        chk("rst_wr_irq", 64'(irq), 64'(0));
        chk("rst_wr_p_reg", p_reg_o, 64'(0));
        @(negedge wb_clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_rst_n = 1'b1;
        out_m[0] = RV; out_m[1] = RV;
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h0, lat);
        chk("rst_rel_lat", 64'(lat), 64'(1));
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h0, lat);
        bus(1'b0, 4'd5, 4'h0, 32'h0, 32'h0, lat);
        bus(1'b0, 4'd4, 4'h0, 32'h0, 32'h3, lat);
        chk("post_rst_irq", 64'(irq), 64'(0));

        repeat (3) @(negedge wb_clk);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_regbank.md
WB_REGBANK -- requirements
Module: wb_regbank

Interface
REQ-001 The block SHALL have parameter NOUT, default 2, meaning the number of 32-bit output registers (1..8).
REQ-002 The block SHALL have parameter NIN, default 2, meaning the number of 32-bit input registers (1..8).
REQ-003 The block SHALL have parameter AW, default 4, meaning the word-address width.
REQ-004 The block SHALL have parameter PULSE_MASK, default 32'h0, meaning the bits of every output register that self-clear.
REQ-005 The block SHALL have parameter RESET_VAL, default 32'h0, meaning the reset value of every output register.
REQ-006 Port wb_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port wb_rst_n  in  1  SHALL be the reset, synchronous and active-low.
REQ-008 Ports wb_cyc, wb_stb, wb_we  in  1 each SHALL be the Wishbone cycle, strobe and write-enable.
REQ-009 Port wb_adr  in  AW  SHALL be the word address.
REQ-010 Port wb_sel  in  4  SHALL be the byte lanes for writes; bit k enables dat_i[8k+7:8k].
REQ-011 Port wb_dat_i  in  32  SHALL be the write data.
REQ-012 Port wb_dat_o  out  32  SHALL be the registered read data.
REQ-013 Port wb_ack  out  1  SHALL be the registered acknowledge.
REQ-014 Port reg_o  out  NOUT*32  SHALL carry the output registers; register i on bits [32i+31:32i].
REQ-015 Port reg_i  in  NIN*32  SHALL carry asynchronous input words; word j on bits [32j+31:32j].
REQ-016 Port irq  out  1  SHALL be the registered, level interrupt.

Function
REQ-017 Address map SHALL be: 0..NOUT-1 output regs (R/W); NOUT..NOUT+NIN-1 input regs (RO); NOUT+NIN CHG (NIN bits, W1C); NOUT+NIN+1 MASK (NIN bits, R/W); all other addresses read 0, writes ignored, still acked.
REQ-018 A request SHALL be accepted when wb_cyc & wb_stb & !wb_ack; wb_ack SHALL go high on the next edge for exactly one cycle, so back-to-back accesses ack at most every other cycle.
REQ-019 An accepted write SHALL take effect on the same edge that raises wb_ack, honouring wb_sel per byte; unselected bytes SHALL be unchanged.
REQ-020 An accepted read SHALL load wb_dat_o on the same edge that raises wb_ack; wb_dat_o SHALL hold its value otherwise; unused CHG/MASK bits read 0.
REQ-021 Bits set in PULSE_MASK SHALL read back and drive reg_o as 1 for exactly one cycle after a write of 1, then clear to 0 without a bus access.
REQ-022 Each reg_i word SHALL pass a two-flop synchronizer; the input register readback SHALL be the second stage (2-cycle latency).
REQ-023 A third stage SHALL hold the previous synchronized value; CHG[j] SHALL set on the edge after stage2 != stage3 for word j.
REQ-024 Writing 1 to CHG[j] SHALL clear it; if set and clear coincide in the same cycle, set SHALL win.
REQ-025 irq SHALL be registered: irq <= |(CHG & MASK), one cycle after CHG or MASK changes.
REQ-026 Unaccepted cycles (wb_cyc or wb_stb low) SHALL change no register except sync stages, CHG set, pulse clears and irq.

Reset
REQ-027 When wb_rst_n is low at a rising edge, reg_o words SHALL become RESET_VAL, and wb_ack, wb_dat_o, CHG, MASK, irq and all synchronizer stages SHALL become 0.
REQ-028 Reset SHALL override any concurrent write, set or clear; a request in flight SHALL be dropped with no ack.
REQ-029 The first edge with wb_rst_n high SHALL be able to accept a request.
REQ-030 The first change detection after reset SHALL compare against the zeroed stage3, so a nonzero reg_i sets CHG 3 cycles after reset release.

Verification
REQ-031 Write 0xA5A5A5A5 to adr 1 with sel=4'b0101, over 0x11223344 -> readback 0x11A533A5, reg_o[63:32] equals it, ack one cycle.
REQ-032 PULSE_MASK=0x1, write 0x3 to adr 0 -> reg_o[0] high exactly one cycle, reg_o[1] stays 1, readback 0x2.
REQ-033 reg_i word 0 goes 0 -> 0x00000055, MASK=0x1 -> adr 2 reads 0x55 after 2 cycles, CHG=0x1, irq high 1 cycle later; write 0x1 to CHG -> irq low.
REQ-034 Input word 1 changes on the same edge as a W1C of CHG[1] -> CHG[1] remains 1.
REQ-035 Continuous cyc&stb for 6 cycles reading adr 7 -> ack pattern 0,1,0,1,0,1, data 0 each ack.
REQ-036 Assert wb_rst_n low during an accepted write to adr 0 -> no ack, reg_o=RESET_VAL, CHG=MASK=irq=0.
